// File: rtl/inst_fifo_pkg.sv
// Shared CPU definitions for the fetch-to-decode instruction queue.
package inst_fifo_pkg;

   // Default instruction queue depth (entries, power of two).
   localparam int INST_FIFO_DEPTH = 16;

   // One queued instruction: fetch PC plus the instruction word.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } inst_entry_t;

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side signals of the instruction queue.
interface inst_fifo_if;

   logic        fifo_rst;
   logic        write_en1;
   logic        write_en2;
   logic [31:0] write_inst1;
   logic [31:0] write_inst2;
   logic [31:0] write_addr1;
   logic [31:0] write_addr2;
   logic        read_en1;
   logic        read_en2;
   logic [31:0] read_inst1;
   logic [31:0] read_inst2;
   logic [31:0] read_addr1;
   logic [31:0] read_addr2;
   logic        empty;
   logic        almost_empty;
   logic        full;

   // Fetch/decode pipeline side.
   modport master (
      output fifo_rst, write_en1, write_en2, write_inst1, write_inst2,
             write_addr1, write_addr2, read_en1, read_en2,
      input  read_inst1, read_inst2, read_addr1, read_addr2,
             empty, almost_empty, full
   );

   // Queue side.
   modport slave (
      input  fifo_rst, write_en1, write_en2, write_inst1, write_inst2,
             write_addr1, write_addr2, read_en1, read_en2,
      output read_inst1, read_inst2, read_addr1, read_addr2,
             empty, almost_empty, full
   );

endinterface

// File: rtl/inst_fifo_mem.sv
// Entry storage: two write ports, two asynchronous read ports, no reset.
module inst_fifo_mem
   import inst_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_a,
   input  logic [PTR_W-1:0]  waddr_a,
   input  inst_entry_t       wdata_a,
   input  logic              we_b,
   input  logic [PTR_W-1:0]  waddr_b,
   input  inst_entry_t       wdata_b,
   input  logic [PTR_W-1:0]  raddr_a,
   output inst_entry_t       rdata_a,
   input  logic [PTR_W-1:0]  raddr_b,
   output inst_entry_t       rdata_b
);

   inst_entry_t mem_q [DEPTH];

   // Write both fetch slots; the controller never gives them the same address.
   always_ff @(posedge clk) begin
      if (we_a) mem_q[waddr_a] <= wdata_a;
      if (we_b) mem_q[waddr_b] <= wdata_b;
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode.
// Validity of the storage is derived purely from count, so neither flush
// nor reset touches the entry array.
module inst_fifo
   import inst_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   inst_fifo_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [1:0]       n_push;
   logic [1:0]       n_pop;
   logic             wr_ok;
   logic             we_a;
   logic             we_b;
   logic [PTR_W-1:0] waddr_b;
   logic [PTR_W-1:0] raddr_b;
   inst_entry_t      wdata_a;
   inst_entry_t      wdata_b;
   inst_entry_t      rdata_a;
   inst_entry_t      rdata_b;
   logic             slot1_vld;
   logic             slot2_vld;

   assign bus.empty        = (count == '0);
   assign bus.almost_empty = (count == CNT_W'(1));
   assign bus.full         = (count > CNT_W'(DEPTH - 2));

   assign slot1_vld = !bus.empty;
   assign slot2_vld = (count >= CNT_W'(2));

   // Work out how many entries move in and out this cycle.
   always_comb begin
      wr_ok  = !bus.full && !bus.fifo_rst;
      n_push = 2'd0;
      n_pop  = 2'd0;
      if (wr_ok)
         n_push = {1'b0, bus.write_en1} + {1'b0, bus.write_en2};
      if (bus.read_en1 && slot1_vld)
         n_pop = (bus.read_en2 && slot2_vld) ? 2'd2 : 2'd1;
   end

   // Pack pushes in slot order: slot 2 lands at tail when slot 1 is idle.
   assign we_a    = wr_ok && bus.write_en1;
   assign we_b    = wr_ok && bus.write_en2;
   assign waddr_b = tail + PTR_W'(bus.write_en1);
   assign wdata_a = '{addr: bus.write_addr1, inst: bus.write_inst1};
   assign wdata_b = '{addr: bus.write_addr2, inst: bus.write_inst2};
   assign raddr_b = head + PTR_W'(1);

   inst_fifo_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we_a    (we_a),
      .waddr_a (tail),
      .wdata_a (wdata_a),
      .we_b    (we_b),
      .waddr_b (waddr_b),
      .wdata_b (wdata_b),
      .raddr_a (head),
      .rdata_a (rdata_a),
      .raddr_b (raddr_b),
      .rdata_b (rdata_b)
   );

   // Pointer and occupancy update; reset beats flush, flush beats push/pop.
   always_ff @(posedge clk) begin
      if (rst || bus.fifo_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(n_pop);
         tail  <= tail + PTR_W'(n_push);
         count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
      end
   end

   assign bus.read_inst1 = slot1_vld ? rdata_a.inst : 32'h0;
   assign bus.read_addr1 = slot1_vld ? rdata_a.addr : 32'h0;
   assign bus.read_inst2 = slot2_vld ? rdata_b.inst : 32'h0;
   assign bus.read_addr2 = slot2_vld ? rdata_b.addr : 32'h0;

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The parameter list SHALL be: DEPTH, 16, number of entries (power of two, at least 4).
REQ-002 The port clk SHALL be: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The port rst SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-004 The port fifo_rst SHALL be: input, 1 bit, flush (branch mispredict, exception or eret); discards all entries.
REQ-005 The port write_en1 SHALL be: input, 1 bit, push fetch slot 1.
REQ-006 The port write_en2 SHALL be: input, 1 bit, push fetch slot 2.
REQ-007 The ports write_inst1 and write_inst2 SHALL be: input, 32 bits each, instruction words.
REQ-008 The ports write_addr1 and write_addr2 SHALL be: input, 32 bits each, PCs of those words.
REQ-009 The port read_en1 SHALL be: input, 1 bit, decode consumes head entry.
REQ-010 The port read_en2 SHALL be: input, 1 bit, decode consumes head+1 entry.
REQ-011 The ports read_inst1 and read_inst2 SHALL be: output, 32 bits each, instructions at head and head+1.
REQ-012 The ports read_addr1 and read_addr2 SHALL be: output, 32 bits each, PCs at head and head+1.
REQ-013 The port empty SHALL be: output, 1 bit, count==0.
REQ-014 The port almost_empty SHALL be: output, 1 bit, count==1 (only slot 1 valid).
REQ-015 The port full SHALL be: output, 1 bit, count > DEPTH-2 (no guaranteed room for two pushes).

Function
REQ-016 The block SHALL be a circular buffer with head pointer, tail pointer and count, each log2(DEPTH) bits wide plus 1 bit for count; pointers SHALL wrap modulo DEPTH.
REQ-017 Read outputs SHALL be combinational from the storage: slot 1 = entry[head], slot 2 = entry[(head+1) mod DEPTH]; zero-latency visibility to decode.
REQ-018 A slot that is not valid SHALL drive 32'h0 on both inst and addr (slot 1 invalid when empty; slot 2 invalid when empty or almost_empty).
REQ-019 Number pushed SHALL be write_en1 + write_en2, packed in order: slot 1 word at tail, slot 2 word at tail+1; write_en2 alone writes slot 2 word at tail.
REQ-020 Number popped SHALL be: 0 if read_en1=0; 1 if read_en1=1 and (read_en2=0 or count<2); 2 otherwise; read_en1 with empty=1 pops 0; read_en2 without read_en1 is ignored.
REQ-021 When full=1 at the clock edge, all pushes that cycle SHALL be dropped (pointer and count unchanged by writes); pops still apply.
REQ-022 Push and pop in the same cycle SHALL both take effect: count_next = count + pushed - popped; the pointers advance independently.
REQ-023 Push into an empty FIFO SHALL become visible on read outputs in the next cycle (no write-through).
REQ-024 fifo_rst=1 SHALL have priority over push and pop: head, tail and count become 0 next cycle, and that cycle's writes are discarded.
REQ-025 Storage contents SHALL NOT need clearing on flush or reset; validity derives solely from count.
REQ-026 The block SHALL hold no other state (no FSM beyond pointers/count); count SHALL never exceed DEPTH nor underflow.

Reset
REQ-027 On rst=1 at a clock edge, head, tail and count SHALL be 0; next-cycle outputs: empty=1, almost_empty=0, full=0, read_inst/addr = 0.
REQ-028 rst SHALL have priority over fifo_rst, push and pop; reset mid-operation discards all entries.

Structure
REQ-029 The DEPTH default SHALL live in the shared CPU package, as a localparam named in the team style.
REQ-030 The instruction-entry struct {addr[31:0], inst[31:0]} SHALL live in the shared CPU package for reuse by decode.
REQ-031 One sub-module, inst_fifo_mem, SHALL be natural: a DEPTH x 64 register array with 2 write ports and 2 asynchronous read ports, no reset.
REQ-032 Pointer and count logic SHALL remain in inst_fifo.

Verification
REQ-033 Reset, then push (0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004): the bench SHALL observe next cycle count=2, read_inst1=0x24010001, read_addr2=0xBFC00004, empty=0.
REQ-034 Push 15 single words: the bench SHALL observe full=1 at count=15; a further dual push is dropped; pop 2 then gives count=13 and full=0.
REQ-035 With count=1 assert read_en1 and read_en2: the bench SHALL observe only 1 popped, empty=1 next cycle, and slot 2 outputs 0 while almost_empty=1.
REQ-036 Fill to 10, pop 2 and push 2 simultaneously for 20 cycles crossing wrap: the bench SHALL observe FIFO order preserved, with PCs strictly +4 sequential.
REQ-037 With count=6 assert fifo_rst together with write_en1, write_en2, read_en1: the bench SHALL observe count=0, empty=1 next cycle, and no stale data on later pushes.
REQ-038 Assert rst with count=8 and pushes active: the bench SHALL observe all pointers 0, empty=1 and full=0 next cycle.
